// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI controller/peripheral pair.
package spi_pkg;
  localparam int SPI_BYTE_W   = 8;
  localparam int SPI_BITCNT_W = 3;

  typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} spi_mode_e;
  typedef enum logic {IDLE, ACTIVE} spi_periph_state_e;
endpackage

// File: rtl/spi_periph_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin, with rise/fall detect
// against the previous synchronized value.
module spi_periph_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral endpoint oversampled by CLK: byte-wide RX/TX handshake,
// MSB-first shifting under an external SCK and active-low chip select.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_CS_n,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic                  o_SPI_MISO_En,
  input  logic [SPI_BYTE_W-1:0] i_TX_Byte,
  input  logic                  i_TX_DV,
  output logic                  o_TX_Ready,
  output logic [SPI_BYTE_W-1:0] o_RX_Byte,
  output logic                  o_RX_DV
);
  localparam spi_mode_e MODE = spi_mode_e'(SPI_MODE[1:0]);
  localparam logic      CPOL = MODE[1];
  localparam logic      CPHA = MODE[0];

  localparam logic [0:0] ST_IDLE   = 1'(IDLE);
  localparam logic [0:0] ST_ACTIVE = 1'(ACTIVE);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_periph_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .CLK(CLK), .RST(RST), .d(i_SPI_Clk), .sync(sck_s), .rise(sck_rise), .fall(sck_fall));
  spi_periph_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .CLK(CLK), .RST(RST), .d(i_SPI_CS_n), .sync(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_periph_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .CLK(CLK), .RST(RST), .d(i_SPI_MOSI), .sync(mosi_s),
    .rise(unused_mosi_rise), .fall(unused_mosi_fall));

  logic [0:0]              state;
  logic [SPI_BITCNT_W-1:0] bit_cnt;
  logic [SPI_BYTE_W-1:0]   rx_shift, rx_next, tx_shift, hold;
  logic                    tx_ready, ready_init;
  logic                    lead_edge, trail_edge, in_frame, frame_start, frame_end;
  logic                    do_sample, do_shift, load_evt;
  logic                    unused_sync;

  assign unused_sync = ^{sck_s, cs_rise};

  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign in_frame    = (state == ST_ACTIVE) && !cs_s;
  assign frame_start = (state == ST_IDLE) && cs_fall;
  assign frame_end   = (state == ST_ACTIVE) && cs_s;
  assign do_sample   = in_frame && (CPHA ? trail_edge : lead_edge);
  assign do_shift    = in_frame && (CPHA ? lead_edge : trail_edge);
  assign rx_next     = {rx_shift[SPI_BYTE_W-2:0], mosi_s};
  // The counter only reads zero on a shift edge at a byte boundary, so this
  // covers both the CPHA=1 first edge and the CPHA=0 edge after the 8th sample.
  assign load_evt    = (do_shift && (bit_cnt == '0)) || (!CPHA && frame_start);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else if (frame_start) begin
      state <= ST_ACTIVE;
    end else if (frame_end) begin
      state <= ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_shift  <= '0;
      bit_cnt   <= '0;
      o_RX_Byte <= '0;
      o_RX_DV   <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      if (frame_end) begin
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (do_sample) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + SPI_BITCNT_W'(1);
        if (bit_cnt == '1) begin
          o_RX_Byte <= rx_next;
          o_RX_DV   <= 1'b1;
        end
      end
    end
  end

  // tx_ready doubles as "holding register empty"; it comes up one CLK after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_shift   <= '0;
      hold       <= '0;
      tx_ready   <= 1'b0;
      ready_init <= 1'b0;
    end else begin
      ready_init <= 1'b1;
      if (load_evt) begin
        if (tx_ready) begin
          tx_shift <= '0;
          if (i_TX_DV) begin
            hold     <= i_TX_Byte;
            tx_ready <= 1'b0;
          end
        end else begin
          tx_shift <= hold;
          tx_ready <= 1'b1;
        end
      end else begin
        if (do_shift) begin
          tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
        end
        if (i_TX_DV && tx_ready) begin
          hold     <= i_TX_Byte;
          tx_ready <= 1'b0;
        end else if (!ready_init) begin
          tx_ready <= 1'b1;
        end
      end
    end
  end

  assign o_SPI_MISO    = tx_shift[SPI_BYTE_W-1];
  assign o_SPI_MISO_En = (state == ST_ACTIVE);
  assign o_TX_Ready    = tx_ready;
endmodule
